imem_loader: RTL

- Upstream feeder for the single-cycle MIPS core.
- Receives a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit instruction words.
- Writes each word into the instruction memory's write port and holds the core in reset until the whole program is loaded.
- Once loading completes, releases the core so the program runs from PC = 0.

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the word/byte geometry used when packing the byte stream.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes big-endian into 32-bit words. The first byte
// of a word lands in [31:24]. wordValid/wordData flag the beat that completes
// a word, so the owner can register the finished word on that same edge.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byteIn,
    output logic        wordValid,
    output logic [31:0] wordData
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] buffer_q;
    logic [1:0]  byteCnt_q;

    assign wordData  = {buffer_q[23:0], byteIn};
    assign wordValid = accept && (byteCnt_q == LAST_BYTE);

    // Shift buffer and wrapping byte counter; a partial word survives stalls
    // and is only discarded by reset or the start of a new session.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer_q  <= '0;
            byteCnt_q <= '0;
        end else if (clear) begin
            buffer_q  <= '0;
            byteCnt_q <= '0;
        end else if (accept) begin
            buffer_q  <= wordData;
            byteCnt_q <= byteCnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction memory and holds
// the MIPS core in reset until the whole program has been written.
// Stream format: len[15:8], len[7:0], then len big-endian 32-bit words.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    // One extra index bit so the index can reach DEPTH itself on the last word.
    localparam int          IW      = AW + 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t state_q;
    logic [15:0]   len_q;
    logic [IW-1:0] wordIdx_q;

    logic          byteFire_d;
    logic          sessionStart_d;
    logic [15:0]   lenFull_d;
    logic [IW-1:0] nextIdx_d;
    logic          wordValid;
    logic [31:0]   wordData;

    assign byteFire_d     = in_valid && in_ready;
    assign sessionStart_d = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign lenFull_d      = {len_q[15:8], in_data};
    assign nextIdx_d      = wordIdx_q + 1'b1;

    byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (sessionStart_d),
        .accept    (byteFire_d && (state_q == DATA)),
        .byteIn    (in_data),
        .wordValid (wordValid),
        .wordData  (wordData)
    );

    // Session FSM with registered handshake, write-port and core-control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wordIdx_q  <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= LEN_HI;
                        wordIdx_q  <= '0;
                        in_ready   <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (byteFire_d) begin
                        len_q[15:8] <= in_data;
                        state_q     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (byteFire_d) begin
                        len_q[7:0] <= in_data;
                        if (lenFull_d == 16'd0) begin
                            state_q    <= DONE;
                            in_ready   <= 1'b0;
                            core_reset <= 1'b0;
                            done       <= 1'b1;
                        end else if (lenFull_d > DEPTH16) begin
                            state_q  <= ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (wordValid) begin
                        wr_en     <= 1'b1;
                        wr_data   <= wordData;
                        wr_addr   <= {{(32-IW){1'b0}}, wordIdx_q} << WORD_SHIFT;
                        wordIdx_q <= nextIdx_d;
                        if ({{(16-IW){1'b0}}, nextIdx_d} == len_q) begin
                            state_q    <= DONE;
                            in_ready   <= 1'b0;
                            core_reset <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready   <= 1'b0;
                    core_reset <= 1'b1;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

endmodule
